fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the execute stage's forwarding muxes: generates the 2-bit forwardA/forwardB selects the execute stage consumes, plus the load-use stall and bubble.
- Sits beside the ID/EX boundary.
- Tracks destination-register state of the instructions in EX and MEM in its own shadow pipeline.
- Selects are registered, so they are valid throughout the cycle the instruction occupies EX.

Parameters:
- REG_NUM_BITWIDTH, 5, register index width.
- FWD_REG, 2'b00, select: register-file operand.
- FWD_MEM_WB, 2'b01, select: MEM/WB forward data.
- FWD_EX_MEM, 2'b10, select: EX/MEM forward data.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_NUM_BITWIDTH  ID source register 1.
- id_rs2  in  REG_NUM_BITWIDTH  ID source register 2.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_NUM_BITWIDTH  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch/jump resolved taken; kill instruction in ID.
- pipe_hold  in  1  global freeze (memory wait).
- forwardA  out  2  registered select for EX operand A.
- forwardB  out  2  registered select for EX operand B.
- stall  out  1  combinational; hold PC and IF/ID.
- bubble  out  1  combinational; load NOP into ID/EX.

Behaviour:
- Reset (async, rst_n low):
  - ex_valid and mem_valid cleared.
  - All shadow rd fields cleared to 0.
  - forwardA = forwardB = FWD_REG.
  - stall = bubble = 0 whenever no slot is valid.
- Shadow slots:
  - EX slot: ex_valid, ex_rd, ex_rw, ex_mr.
  - MEM slot: mem_valid, mem_rd, mem_rw.
- Hazard match for source s (rs1 or rs2):
  - hitEX(s) = ex_valid & ex_rw & ex_rd!=0 & ex_rd==s.
  - hitMEM(s) = mem_valid & mem_rw & mem_rd!=0 & mem_rd==s.
- load_use = id_valid & ex_mr & ((id_uses_rs1 & hitEX(rs1)) | (id_uses_rs2 & hitEX(rs2))).
- Outputs:
  - stall = load_use & ~flush & ~pipe_hold.
  - bubble = stall | (flush & ~pipe_hold).
- Next select per source, computed in ID:
  - uses_rsX=0 or id_valid=0 -> FWD_REG.
  - Else hitEX -> FWD_EX_MEM (youngest wins).
  - Else hitMEM -> FWD_MEM_WB.
  - Else FWD_REG.
  - Value 2'b11 is never produced.
- Clock edge, pipe_hold=1: all state and forwardA/B hold; stall=bubble=0. pipe_hold overrides everything.
- Clock edge, bubble=1:
  - EX slot <- invalid (rd=0, rw=0, mr=0).
  - forwardA/B <- FWD_REG.
  - MEM slot <- EX slot.
- Clock edge, normal advance:
  - EX slot <- ID fields, with valid = id_valid.
  - forwardA/B <- next selects.
  - MEM slot <- EX slot.
- Load-use, single-cycle penalty:
  - The stall cycle moves the load into MEM.
  - On re-presentation, the same ID instruction resolves to FWD_MEM_WB.
- Simultaneous flush and load_use: flush wins. Instruction killed; stall=0, bubble=1.
- rd==x0 never forwards and never stalls.
- Reset asserted mid-stall clears everything; the first post-reset cycle must show stall=0.
- WB-to-ID hazard (write in same cycle as read) is the register file's write-first responsibility, not this block's.

Decomposition:
- Shared package holds:
  - Forward-select constants FWD_REG, FWD_MEM_WB, FWD_EX_MEM.
  - Shadow-slot struct: valid, rd, reg_write, mem_read.
  - REG_NUM_BITWIDTH.
- One natural sub-module: fwd_select. Purely combinational; maps (rs, uses, EX slot, MEM slot) to (2-bit select, hitEX), instantiated twice for rs1/rs2.
- Sequencing, stall, bubble and reset stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-run with ex slot = load x5 -> forwardA=forwardB=00, stall=0, bubble=0, asynchronously before the next edge.
- ALU-ALU: add x5 then sub x6,x5,x7 back-to-back -> forwardA=10, forwardB=00 when sub is in EX; no stall.
- Distance two: add x5, nop, or x8,x7,x5 -> forwardB=01. Also, with x5 written in both EX and MEM slots, forwardB=10 (priority).
- Load-use: lw x5 then add x6,x5,x5 -> stall=1 and bubble=1 for exactly one cycle. Next cycle forwardA=forwardB=01; no 11 ever.
- x0 and unused sources:
  - addi x0 then add x1,x0,x0 -> selects 00.
  - lw x3 then lui x3 (id_uses_rs1=id_uses_rs2=0) -> no stall.
- Flush/hold:
  - flush together with load_use -> stall=0, bubble=1.
  - pipe_hold=1 for 3 cycles during a forwarding case -> forwardA/B and slots unchanged, stall=0. Afterwards, sequence resumes with identical selects.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared definitions for the forwarding / hazard control block:
//   - REG_NUM_BITWIDTH : architectural register index width
//   - FWD_*            : 2-bit operand select encodings consumed by EX
//   - slot_t           : shadow copy of the destination-register state of
//                        one pipeline stage (EX or MEM)
//   - slot_hit()       : "this slot will write register r" (x0 never hits)
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    localparam int REG_NUM_BITWIDTH = 5;

    localparam logic [1:0] FWD_REG    = 2'b00;  // register-file operand
    localparam logic [1:0] FWD_MEM_WB = 2'b01;  // MEM/WB forward data
    localparam logic [1:0] FWD_EX_MEM = 2'b10;  // EX/MEM forward data

    typedef struct packed {
        logic                        valid;
        logic [REG_NUM_BITWIDTH-1:0] rd;
        logic                        reg_write;
        logic                        mem_read;
    } slot_t;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    function automatic logic slot_hit(input slot_t s,
                                      input logic [REG_NUM_BITWIDTH-1:0] r);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Purely combinational per-source forward select. One instance per
//   source operand (rs1 / rs2).
//   Ports:
//     id_valid  in   ID holds a real instruction
//     rs        in   source register index
//     uses      in   instruction actually reads this source
//     ex_slot   in   shadow state of the instruction now in EX
//     mem_slot  in   shadow state of the instruction now in MEM
//     sel       out  next-cycle select (FWD_REG / FWD_MEM_WB / FWD_EX_MEM)
//     hit_ex    out  raw EX-slot match, used by the load-use detector
// ---------------------------------------------------------------------------
module fwd_select
    import fwd_hazard_unit_pkg::*;
(
    input  logic                        id_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] rs,
    input  logic                        uses,
    input  slot_t                       ex_slot,
    input  slot_t                       mem_slot,
    output logic [1:0]                  sel,
    output logic                        hit_ex
);

    logic hit_mem;
    logic unused_mr;

    assign hit_ex  = slot_hit(ex_slot, rs);
    assign hit_mem = slot_hit(mem_slot, rs);

    // mem_read only matters to the load-use detector in the parent.
    assign unused_mr = ex_slot.mem_read | mem_slot.mem_read;

    // The EX-stage producer is younger than the MEM-stage one, so its
    // value is the architecturally current one and takes priority.
    always_comb begin
        sel = FWD_REG;
        if (id_valid && uses) begin
            if (hit_ex)
                sel = FWD_EX_MEM;
            else if (hit_mem)
                sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Control side of the EX-stage forwarding muxes. Keeps a shadow copy of
//   the destination-register state of the instructions in EX and MEM,
//   computes the forward selects for the instruction in ID and registers
//   them so they are stable for the whole cycle that instruction sits in
//   EX. Also detects load-use hazards (one stall cycle + bubble).
//   Ports:
//     clk, rst_n                 clock (rising) / async active-low reset
//     id_valid                   ID holds a real instruction
//     id_rs1, id_rs2             ID source registers
//     id_uses_rs1, id_uses_rs2   instruction reads the source
//     id_rd, id_reg_write        ID destination and write enable
//     id_mem_read                ID instruction is a load
//     flush                      taken branch/jump, kill ID instruction
//     pipe_hold                  global freeze
//     forwardA, forwardB         registered operand selects for EX
//     stall                      combinational; hold PC and IF/ID
//     bubble                     combinational; load NOP into ID/EX
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
    input  logic                        id_uses_rs1,
    input  logic                        id_uses_rs2,
    input  logic [REG_NUM_BITWIDTH-1:0] id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_mem_read,
    input  logic                        flush,
    input  logic                        pipe_hold,
    output logic [1:0]                  forwardA,
    output logic [1:0]                  forwardB,
    output logic                        stall,
    output logic                        bubble
);

    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      id_slot;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       hit_ex_a;
    logic       hit_ex_b;
    logic       load_use;

    fwd_select u_sel_a (
        .id_valid (id_valid),
        .rs       (id_rs1),
        .uses     (id_uses_rs1),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_a),
        .hit_ex   (hit_ex_a)
    );

    fwd_select u_sel_b (
        .id_valid (id_valid),
        .rs       (id_rs2),
        .uses     (id_uses_rs2),
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .sel      (sel_b),
        .hit_ex   (hit_ex_b)
    );

    assign id_slot = '{valid:     id_valid,
                       rd:        id_rd,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read};

    // A load in EX has no data yet; a consumer in ID must wait one cycle,
    // after which the load is in MEM and the MEM/WB path covers it.
    assign load_use = id_valid & ex_slot.mem_read &
                      ((id_uses_rs1 & hit_ex_a) | (id_uses_rs2 & hit_ex_b));

    // pipe_hold freezes everything, so neither stall nor bubble may fire;
    // flush kills the ID instruction, so its load-use stall is moot.
    assign stall  = load_use & ~flush & ~pipe_hold;
    assign bubble = stall | (flush & ~pipe_hold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            forwardA <= FWD_REG;
            forwardB <= FWD_REG;
        end else if (!pipe_hold) begin
            mem_slot <= ex_slot;
            if (bubble) begin
                ex_slot  <= '0;
                forwardA <= FWD_REG;
                forwardB <= FWD_REG;
            end else begin
                ex_slot  <= id_slot;
                forwardA <= sel_a;
                forwardB <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed, table-driven bench. Each table row is one ID-stage cycle:
//   inputs are driven after the falling edge, stall/bubble are compared
//   before the rising edge, forwardA/B are compared just after it.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        id_valid;
    logic [REG_NUM_BITWIDTH-1:0] id_rs1, id_rs2, id_rd;
    logic                        id_uses_rs1, id_uses_rs2;
    logic                        id_reg_write, id_mem_read;
    logic                        flush, pipe_hold;
    logic [1:0]                  forwardA, forwardB;
    logic                        stall, bubble;

    int n_checks = 0;
    int n_pass   = 0;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .pipe_hold    (pipe_hold),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .stall        (stall),
        .bubble       (bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr, fl, hd;
        logic       es, eb;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr,
                                input logic fl, input logic hd,
                                input logic es, input logic eb,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl; t.hd = hd;
        t.es = es; t.eb = eb; t.fa = fa; t.fb = fb;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_rs1       = t.rs1;
        id_rs2       = t.rs2;
        id_uses_rs1  = t.u1;
        id_uses_rs2  = t.u2;
        id_rd        = t.rd;
        id_reg_write = t.rw;
        id_mem_read  = t.mr;
        flush        = t.fl;
        pipe_hold    = t.hd;
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("%s[%0d].stall", tag, i),  int'(stall),  int'(vecs[i].es));
            chk($sformatf("%s[%0d].bubble", tag, i), int'(bubble), int'(vecs[i].eb));
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].fwdA", tag, i), int'(forwardA), int'(vecs[i].fa));
            chk($sformatf("%s[%0d].fwdB", tag, i), int'(forwardB), int'(vecs[i].fb));
        end
    endtask

    initial begin
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        drive(nop);
        rst_n = 1'b0;
        #1;
        chk("reset.fwdA",   int'(forwardA), 0);
        chk("reset.fwdB",   int'(forwardB), 0);
        chk("reset.stall",  int'(stall),    0);
        chk("reset.bubble", int'(bubble),   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //           v rs1 rs2 u1 u2 rd rw mr fl hd  es eb  fa     fb
        // ALU-ALU: add x5,x1,x2 ; sub x6,x5,x7
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00));
        // distance two: add x5 ; nop ; or x8,x7,x5
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(nop);
        vecs.push_back(mk(1, 7, 5, 1, 1, 8, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01));
        // priority: add x5 ; add x5 ; or x9,x7,x5 -> youngest (EX) wins
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 7, 5, 1, 1, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10));
        // load-use: lw x5,0(x1) ; add x6,x5,x5 (stall, then re-presented)
        vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01));
        // x0: addi x0,x1 ; add x1,x0,x0
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        // unused sources: lw x3,0(x2) ; lui x3 -> no stall
        vecs.push_back(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 3, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        // flush with load-use: lw x7 ; add x8,x7,x7 + flush ; add x9,x7,x2
        vecs.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mk(1, 7, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        // hold for 3 cycles in a forwarding case, then resume
        vecs.push_back(mk(1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mk(1, 10, 9, 1, 1, 11, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mk(1, 10, 9, 1, 1, 11, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mk(1, 10, 9, 1, 1, 11, 1, 0, 0, 1, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mk(1, 10, 9, 1, 1, 11, 1, 0, 0, 0, 0, 0, 2'b10, 2'b01));
        // hold masks a pending load-use, which then fires once released
        vecs.push_back(mk(1, 1, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 12, 0, 1, 1, 13, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 12, 0, 1, 1, 13, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        vecs.push_back(mk(1, 12, 0, 1, 1, 13, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        // flush under hold: no bubble, selects hold
        vecs.push_back(mk(1, 12, 0, 1, 1, 14, 1, 0, 1, 1, 0, 0, 2'b01, 2'b00));
        run_table("seq");

        // Reset asserted mid-stall: add x5 ; lw x5,0(x5) ; add x6,x5,x5
        vecs.delete();
        vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00));
        run_table("pre_rst");
        @(negedge clk);
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        #1;
        chk("midstall.stall", int'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.fwdA",   int'(forwardA), 0);
        chk("async_rst.fwdB",   int'(forwardB), 0);
        chk("async_rst.stall",  int'(stall),    0);
        chk("async_rst.bubble", int'(bubble),   0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.stall",  int'(stall),  0);
        chk("post_rst.bubble", int'(bubble), 0);
        @(posedge clk);
        #1;
        chk("post_rst.fwdA", int'(forwardA), 0);
        chk("post_rst.fwdB", int'(forwardB), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
